serial_borrow_subtractor: RTL and testbench
===========================================

Name: serial_borrow_subtractor

Overview:
Parametrised multi-cycle subtractor that computes D = A - B - Bin on WIDTH-bit operands, DIGIT bits per clock. The borrow is held in a register between digit steps. Operands enter through a valid/ready handshake, and the result is held until the consumer accepts it. The block also reports signed overflow. It is the pipelined-datapath successor to the 4-bit combinational ripple-borrow subtractor: it trades latency for a short critical path when operands are wide.

Parameters:
WIDTH, 16, operand and result width in bits; legal values are at least 1.
DIGIT, 4, bits processed per RUN cycle; must divide WIDTH exactly (elaboration-time assertion).
NSTEP, WIDTH/DIGIT, derived local parameter (not overridable): number of RUN cycles.

Ports:
clk  in  1  clock; all logic on the rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operands A, B, Bin are valid
in_ready  out  1  block can accept operands; high only in IDLE
A  in  WIDTH  minuend
B  in  WIDTH  subtrahend
Bin  in  1  borrow-in
out_valid  out  1  result valid; high only in DONE
out_ready  in  1  consumer accepts the result
D  out  WIDTH  difference A - B - Bin, modulo 2^WIDTH
Bout  out  1  final borrow-out; 1 when A < B + Bin (unsigned)
ovf  out  1  two's-complement overflow of the signed subtraction

Behaviour:
- Reset is synchronous and active-low on clk. Both clk and rst_n are single-domain, with no CDC.
- While rst_n=0 at an edge: state goes to IDLE, and D, Bout, ovf, out_valid, the step counter, the borrow register and the operand shift registers all clear to 0.
- in_ready=1 during the first cycle after reset.
- in_ready and out_valid are decoded from state only, with no combinational path from any input.
- State machine:
  - IDLE: in_ready=1. On an edge with in_valid=1:
    - capture A and B into shift registers and Bin into the borrow register;
    - latch A[WIDTH-1] and B[WIDTH-1] for the overflow check;
    - clear the step counter;
    - go to RUN.
    With in_valid=0, stay in IDLE.
  - RUN: in_ready=0, out_valid=0. Each edge:
    - subtract the low DIGIT bits of the operand registers using the borrow register;
    - shift the DIGIT difference bits into D from the MSB end, so D is in final order after NSTEP steps;
    - shift both operand registers right by DIGIT;
    - load the borrow register with the digit borrow-out;
    - increment the counter.
    On the edge where counter = NSTEP-1, load Bout and ovf and go to DONE.
  - DONE: out_valid=1, and D, Bout, ovf are held stable. On an edge with out_ready=1, go to IDLE. in_ready rises on the cycle after the output handshake, so there is no same-cycle turnaround.
- Latency: out_valid rises exactly NSTEP edges after the accepting edge. With DIGIT=WIDTH this is one edge. Throughput is one operation per NSTEP+2 cycles minimum.
- Overflow rule: ovf = (A_msb != B_msb) AND (D[WIDTH-1] != A_msb), where A_msb and B_msb are the latched MSBs. Bin takes part only through D.
- Inputs are ignored outside IDLE. in_valid/A/B changes during RUN or DONE have no effect. The D register is updated only in RUN, so it holds the previous result through IDLE.
- Reset asserted mid-RUN or mid-DONE aborts the operation. The next cycle is IDLE with all outputs 0, and no out_valid is produced for the aborted operation.
- Wrap-around: results are modulo 2^WIDTH. Bout=1 flags an unsigned underflow, for example 0 - 1 gives an all-ones D.

Decomposition:
- Shared package:
  - state enum {IDLE, RUN, DONE} (2-bit encoding);
  - counter-width function clog2-based, minimum 1 bit.
- One sub-module: digit_borrow_subtractor, parametrised by DIGIT. It is a combinational ripple of full subtractors with inputs a[DIGIT], b[DIGIT], bin and outputs d[DIGIT], bout. Instantiate it once in the top module.

Test Plan:
1. WIDTH=16, DIGIT=4. A=0x1234, B=0x0234, Bin=0 -> D=0x1000, Bout=0, ovf=0. out_valid rises exactly 4 edges after accept.
2. A=0x0000, B=0x0001, Bin=0 -> D=0xFFFF, Bout=1, ovf=0. This checks that the borrow ripples through all 4 digit steps.
3. A=0x8000, B=0x0001, Bin=0 -> D=0x7FFF, Bout=0, ovf=1. Then A=0x7FFF, B=0xFFFF -> D=0x8000, Bout=1, ovf=1.
4. A=0x0000, B=0x0000, Bin=1 -> D=0xFFFF, Bout=1, ovf=0. Then A=0x0005, B=0x0003, Bin=1 -> D=0x0001, Bout=0.
5. Hold out_ready=0 for 10 cycles in DONE:
   - out_valid, D, Bout and ovf stay stable and in_ready=0;
   - a new in_valid pulse during this time is ignored.
   Then set out_ready=1 -> out_valid falls and in_ready=1 the next cycle.
6. Drive rst_n=0 for one edge at RUN step 2 -> IDLE next cycle, all outputs 0, in_ready=1, no spurious out_valid. Then rebuild with DIGIT=16 and apply A=0x0010, B=0x0001 -> out_valid 1 edge after accept, D=0x000F.

Source files
------------

// File: rtl/serial_borrow_subtractor_pkg.sv
// Shared types and helpers for the serial borrow subtractor.
// Covers the FSM state encoding and the step-counter width.
package serial_borrow_subtractor_pkg;

    localparam logic [1:0] IDLE_ENC = 2'd0;
    localparam logic [1:0] RUN_ENC  = 2'd1;
    localparam logic [1:0] DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        IDLE = IDLE_ENC,
        RUN  = RUN_ENC,
        DONE = DONE_ENC
    } state_t;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_borrow_subtractor.sv
// Combinational ripple of DIGIT full subtractors.
// Computes d = a - b - bin and reports the borrow out of the top bit.
module digit_borrow_subtractor #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    logic [DIGIT:0] br;

    assign br[0] = bin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign d[i]    = a[i] ^ b[i] ^ br[i];
        // A bit borrows when b exceeds a, or when they tie and a borrow arrives.
        assign br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
    end

    assign bout = br[DIGIT];

endmodule

// File: rtl/serial_borrow_subtractor.sv
// Multi-cycle subtractor computing D = A - B - Bin, DIGIT bits per clock.
// Operands enter through a valid/ready handshake; the result is held until accepted.
module serial_borrow_subtractor
    import serial_borrow_subtractor_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             ovf
);

    localparam int             NSTEP = WIDTH / DIGIT;
    localparam int             CW    = cnt_width(NSTEP);
    localparam logic [CW-1:0]  LAST  = CW'(NSTEP - 1);

    if (DIGIT < 1 || WIDTH < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_borrow_subtractor: DIGIT must divide WIDTH exactly");
    end

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_reg;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             a_msb;
    logic             b_msb;
    logic             bout_reg;
    logic             ovf_reg;

    logic [DIGIT-1:0] dig_d;
    logic             dig_bout;
    logic [WIDTH-1:0] dig_ext;
    logic [WIDTH-1:0] d_next;

    digit_borrow_subtractor #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (a_sh[DIGIT-1:0]),
        .b    (b_sh[DIGIT-1:0]),
        .bin  (borrow),
        .d    (dig_d),
        .bout (dig_bout)
    );

    // New digit enters at the MSB end so the low digit lands at bit 0 after NSTEP steps.
    assign dig_ext = WIDTH'(dig_d);
    assign d_next  = (d_reg >> DIGIT) | (dig_ext << (WIDTH - DIGIT));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and the block order does not matter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            d_reg    <= '0;
            cnt      <= '0;
            borrow   <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            bout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= A;
                        b_sh   <= B;
                        borrow <= Bin;
                        a_msb  <= A[WIDTH-1];
                        b_msb  <= B[WIDTH-1];
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    d_reg  <= d_next;
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    borrow <= dig_bout;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        bout_reg <= dig_bout;
                        // The final digit supplies the result MSB.
                        ovf_reg  <= (a_msb != b_msb) && (dig_d[DIGIT-1] != a_msb);
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign D         = d_reg;
    assign Bout      = bout_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Self-checking bench for serial_borrow_subtractor (DIGIT=4 and DIGIT=16 builds).
// Expected results come from a reference model pushed to a scoreboard queue.
module tb_serial_borrow_subtractor;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NSTEP = WIDTH / DIGIT;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             bout;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             ovf;

    logic             v16;
    logic             r16;
    logic [WIDTH-1:0] a16;
    logic [WIDTH-1:0] b16;
    logic             bin16;
    logic             ov16;
    logic             ordy16;
    logic [WIDTH-1:0] d16;
    logic             bo16;
    logic             ovf16;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    serial_borrow_subtractor #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout),
        .ovf       (ovf)
    );

    serial_borrow_subtractor #(
        .WIDTH (WIDTH),
        .DIGIT (WIDTH)
    ) dut_wide (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v16),
        .in_ready  (r16),
        .A         (a16),
        .B         (b16),
        .Bin       (bin16),
        .out_valid (ov16),
        .out_ready (ordy16),
        .D         (d16),
        .Bout      (bo16),
        .ovf       (ovf16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic bin);
        exp_t         e;
        logic [WIDTH:0] r;
        r      = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
        e.d    = r[WIDTH-1:0];
        e.bout = r[WIDTH];
        e.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        return e;
    endfunction

    // One full transaction on the DIGIT=4 instance; hold>0 stalls the consumer in DONE.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic bin, input int hold);
        exp_t e;
        int   edges;
        e = '0;
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        A        = a;
        B        = b;
        Bin      = bin;
        in_valid = 1'b1;
        exp_q.push_back(model(a, b, bin));
        @(negedge clk);
        in_valid = 1'b0;
        A        = 16'(($urandom));
        B        = 16'(($urandom));
        Bin      = 1'b1;
        check("in_ready_run", 32'(in_ready), 32'd0);
        edges = 0;
        while (!out_valid && edges < 50) begin
            @(negedge clk);
            edges++;
        end
        check("latency", 32'(edges), 32'(NSTEP));
        check("out_valid_done", 32'(out_valid), 32'd1);
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check("D", 32'(D), 32'(e.d));
        check("Bout", 32'(Bout), 32'(e.bout));
        check("ovf", 32'(ovf), 32'(e.ovf));
        check("in_ready_done", 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = (i == 3);
            A        = 16'hAAAA;
            B        = 16'h5555;
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_D", 32'(D), 32'(e.d));
            check("hold_Bout", 32'(Bout), 32'(e.bout));
            check("hold_ovf", 32'(ovf), 32'(e.ovf));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_D_held", 32'(D), 32'(e.d));
        if (hold > 0) begin
            @(negedge clk);
            check("ignored_pulse_idle", 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        int   edges;
        int   spurious;
        exp_t e;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        Bin       = 1'b0;
        out_ready = 1'b0;
        v16       = 1'b0;
        a16       = '0;
        b16       = '0;
        bin16     = 1'b0;
        ordy16    = 1'b0;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_D", 32'(D), 32'd0);
        check("rst_Bout", 32'(Bout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        run_op(16'h1234, 16'h0234, 1'b0, 0);
        run_op(16'h0000, 16'h0001, 1'b0, 0);
        run_op(16'h8000, 16'h0001, 1'b0, 0);
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 0);
        run_op(16'h0000, 16'h0000, 1'b1, 0);
        run_op(16'h0005, 16'h0003, 1'b1, 0);
        for (int k = 0; k < 4; k++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 0);
        end
        run_op(16'hC3A5, 16'h4F19, 1'b1, 10);

        // Abort mid-RUN: reset lands on the second step edge.
        @(negedge clk);
        A        = 16'h4321;
        B        = 16'h1111;
        Bin      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_D", 32'(D), 32'd0);
        check("abort_Bout", 32'(Bout), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        check("abort_no_out_valid", 32'(spurious), 32'd0);
        run_op(16'h0100, 16'h0001, 1'b0, 0);

        // Single-step build: the whole word in one RUN edge.
        @(negedge clk);
        check("wide_in_ready", 32'(r16), 32'd1);
        a16   = 16'h0010;
        b16   = 16'h0001;
        bin16 = 1'b0;
        v16   = 1'b1;
        e     = model(16'h0010, 16'h0001, 1'b0);
        @(negedge clk);
        v16   = 1'b0;
        edges = 0;
        while (!ov16 && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check("wide_latency", 32'(edges), 32'd1);
        check("wide_D", 32'(d16), 32'(e.d));
        check("wide_Bout", 32'(bo16), 32'(e.bout));
        check("wide_ovf", 32'(ovf16), 32'(e.ovf));
        ordy16 = 1'b1;
        @(negedge clk);
        ordy16 = 1'b0;
        check("wide_release", 32'(ov16), 32'd0);
        check("wide_idle", 32'(r16), 32'd1);

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
